// File: rtl/uart_tx_unit_if.sv
// uart_tx_unit_if: single-entry write-buffer handshake between a byte producer and the UART transmitter
interface uart_tx_unit_if #(
    parameter int DBIT = 8
);
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic            tx_full;

    modport master (output wr_uart, output w_data, input tx_full);
    modport slave  (input wr_uart, input w_data, output tx_full);
endinterface

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART transmitter with holding register and 16x baud tick; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_unit #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_unit_if.slave  tx_if,
    output logic           tx_busy,
    output logic           tx_done_tick,
    output logic           tx
);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [DVSR_BIT-1:0] DV_LAST = DVSR_BIT'(DVSR - 1);
    localparam logic [5:0]          S_BIT   = 6'd15;
    localparam logic [5:0]          S_STOP  = 6'(SB_TICK - 1);
    localparam logic [2:0]          N_LAST  = 3'(DBIT - 1);

    state_t              state_q, state_d;
    logic [DVSR_BIT-1:0] cnt_q, cnt_d;
    logic [5:0]          s_q, s_d;
    logic [2:0]          n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic [DBIT-1:0]     hold_q, hold_d;
    logic                full_q, full_d;
    logic                tx_q, tx_d;
    logic                par_q, par_d;
    logic                s_tick;

    assign s_tick        = cnt_q == DV_LAST;
    assign tx_if.tx_full = full_q;
    assign tx            = tx_q;

    // State and datapath registers; reset aborts any frame and parks the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
            par_q   <= par_d;
        end
    end

    // Next state: baud counter, holding register accept, and frame sequencing on oversample ticks
    always_comb begin
        state_d = state_q;
        cnt_d   = s_tick ? '0 : cnt_q + 1'b1;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        hold_d  = hold_q;
        full_d  = full_q;
        par_d   = par_q;
        if (tx_if.wr_uart && !full_q) begin
            full_d = 1'b1;
            hold_d = tx_if.w_data;
        end
        unique case (state_q)
            IDLE: if (full_q) begin
                state_d = START;
                cnt_d   = '0;
                s_d     = '0;
                b_d     = hold_q;
                par_d   = ^hold_q;
                full_d  = 1'b0;
            end
            START: if (s_tick) begin
                s_d = (s_q == S_BIT) ? '0 : s_q + 6'd1;
                if (s_q == S_BIT) begin
                    state_d = DATA;
                    n_d     = '0;
                end
            end
            DATA: if (s_tick) begin
                s_d = (s_q == S_BIT) ? '0 : s_q + 6'd1;
                if (s_q == S_BIT) begin
                    b_d = b_q >> 1;
                    n_d = n_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (n_q == N_LAST) state_d = PAR;
`else
                    if (n_q == N_LAST) state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: if (s_tick) begin
                s_d = (s_q == S_BIT) ? '0 : s_q + 6'd1;
                if (s_q == S_BIT) state_d = STOP;
            end
`endif
            STOP: if (s_tick) begin
                s_d = (s_q == S_STOP) ? '0 : s_q + 6'd1;
                if (s_q == S_STOP) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: line level is computed from the next state so tx is registered and edge-aligned with the FSM
    always_comb begin
`ifdef UART_TX_PARITY_EN
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? b_d[0] : (state_d == PAR) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? b_d[0] : 1'b1;
`endif
        tx_busy      = state_q != IDLE;
        tx_done_tick = (state_q == STOP) && s_tick && (s_q == S_STOP);
    end
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed self-checking bench for uart_tx_unit at DVSR=4
module tb_uart_tx_unit;
`ifdef UART_TX_PARITY_EN
    localparam int FLEN = 704;
    localparam bit PEN  = 1'b1;
`else
    localparam int FLEN = 640;
    localparam bit PEN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx_busy, tx_done_tick, tx;
    int   checks = 0;
    int   errors = 0;

    uart_tx_unit_if #(.DBIT(8)) bus ();

    uart_tx_unit #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_BIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_if        (bus.slave),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] exp;
        logic       par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        @(posedge clk); #1;
        bus.wr_uart = 1'b1;
        bus.w_data  = d;
        @(posedge clk); #1;
        bus.wr_uart = 1'b0;
    endtask

    task automatic rx_frame(output logic [7:0] d, output logic p, output bit ok);
        int t;
        ok = 1'b1; d = '0; p = 1'b0; t = 0;
        while (tx !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            ok = 1'b0;
            return;
        end
        repeat (32) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            d[i] = tx;
        end
        if (PEN) begin
            repeat (64) @(negedge clk);
            p = tx;
        end
        repeat (64) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (tx_busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = t < 2000;
    endtask

    function automatic logic exp_tx(input logic [7:0] d, input logic p, input int k);
        int seg;
        seg = k / 64;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return d[seg-1];
        if (PEN && seg == 9) return p;
        return 1'b1;
    endfunction

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        logic       rp;
        bit         ok;
        int         bad, dones, dpos, t;

        vecs[0] = '{8'h55, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 8'hA3, 1'b0};
        vecs[2] = '{8'h07, 8'h07, 1'b1};
        vecs[3] = '{8'h03, 8'h03, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b1};

        bus.wr_uart = 1'b0;
        bus.w_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_full", bus.tx_full, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done_tick, 0);
        reset = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.tx_full !== 1'b0 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
        end
        chk("idle_1000", bad, 0);

        wr(8'h55);
        chk("w55_full_n1", bus.tx_full, 1);
        chk("w55_tx_n1", tx, 1);
        @(posedge clk); #1;
        chk("w55_full_n2", bus.tx_full, 0);
        chk("w55_tx_n2", tx, 0);
        chk("w55_busy_n2", tx_busy, 1);
        bad = 0; dones = 0; dpos = -1;
        for (int k = 0; k < FLEN; k++) begin
            if (tx !== exp_tx(8'h55, 1'b0, k)) bad++;
            if (tx_done_tick === 1'b1) begin
                dones++;
                dpos = k;
            end
            @(posedge clk); #1;
        end
        chk("w55_wave", bad, 0);
        chk("w55_done_cnt", dones, 1);
        chk("w55_done_pos", dpos, FLEN - 1);
        chk("w55_end_busy", tx_busy, 0);
        chk("w55_end_tx", tx, 1);

        for (int v = 0; v < 6; v++) begin
            wr(vecs[v].d);
            rx_frame(rd, rp, ok);
            chk($sformatf("vec%0d_frame", v), ok, 1);
            chk($sformatf("vec%0d_data", v), rd, vecs[v].exp);
            if (PEN) chk($sformatf("vec%0d_par", v), rp, vecs[v].par);
            wait_idle(ok);
            chk($sformatf("vec%0d_idle", v), ok, 1);
        end

        fork
            begin
                rx_frame(rd, rp, ok);
                chk("b2b_f1_ok", ok, 1);
                chk("b2b_f1_data", rd, 8'hA3);
                rx_frame(rd, rp, ok);
                chk("b2b_f2_ok", ok, 1);
                chk("b2b_f2_data", rd, 8'h0F);
            end
            begin
                wr(8'hA3);
                repeat (200) @(posedge clk);
                wr(8'h0F);
                chk("b2b_full_q", bus.tx_full, 1);
                wr(8'hFF);
                chk("b2b_full_drop", bus.tx_full, 1);
                t = 0;
                while (tx_done_tick !== 1'b1 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                chk("b2b_done_seen", t < 2000, 1);
                chk("b2b_full_at_done", bus.tx_full, 1);
                @(negedge clk);
                chk("b2b_idle_tx", tx, 1);
                @(negedge clk);
                chk("b2b_start_tx", tx, 0);
                chk("b2b_full_clr", bus.tx_full, 0);
            end
        join
        wait_idle(ok);
        chk("b2b_idle", ok, 1);
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("b2b_no_third", bad, 0);

        wr(8'h81);
        repeat (200) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_full", bus.tx_full, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        wr(8'h42);
        rx_frame(rd, rp, ok);
        chk("after_rst_ok", ok, 1);
        chk("after_rst_data", rd, 8'h42);
        wait_idle(ok);
        chk("after_rst_idle", ok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
